contador_pontos_bcd: RTL and testbench

CONTADOR_PONTOS_BCD -- requirements
Module: contador_pontos_bcd

---
 rtl/contador_pontos_bcd.sv | 207 ++++++++++++++++++++
 tb/tb_contador_pontos_bcd.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/contador_pontos_bcd.sv
// Three-digit BCD score counter (000-999) driven by one-shot point requests.
// A rising edge on add1/add2/add3 schedules 1/2/3 single-point increments,
// and a rising edge on sub1 schedules one decrement. Points are applied one
// per clock while busy is high, with BCD carry and borrow between digits.
// Each operation ends with a one-cycle done pulse. Hitting 999 on an
// increment, or 000 on a decrement, sets the sticky sat flag and drops the
// points that are still pending.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request rising edge; busy low
// INC     | applying +1 per clock until remaining runs out or 999 hit
// DEC     | applying -1 per clock until remaining runs out or 000 hit

module contador_pontos_bcd (
  input  logic       clk,
  input  logic       nReset,
  input  logic       add1,
  input  logic       add2,
  input  logic       add3,
  input  logic       sub1,
  input  logic       clear,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic       busy,
  output logic       sat,
  output logic       done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INC  = 2'd1;
  localparam logic [1:0] ST_DEC  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic [3:0] dig2_q, dig2_d;
  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;
  logic       sat_q, sat_d;
  logic       done_q, done_d;
  // request bit order: {sub1, add3, add2, add1}
  logic [3:0] prior_q, prior_d;

  logic [3:0] req;
  logic [3:0] rise;
  logic [3:0] inc2, inc1, inc0;
  logic [3:0] dec2, dec1, dec0;
  logic       at_max, at_min;

  assign req  = {sub1, add3, add2, add1};
  assign rise = req & ~prior_q;

  assign at_max = (dig2_q == 4'd9) && (dig1_q == 4'd9) && (dig0_q == 4'd9);
  assign at_min = (dig2_q == 4'd0) && (dig1_q == 4'd0) && (dig0_q == 4'd0);

  // BCD +1 with ripple carry; only used when the score is below 999
  always_comb begin
    inc2 = dig2_q;
    inc1 = dig1_q;
    inc0 = dig0_q;
    if (dig0_q == 4'd9) begin
      inc0 = 4'd0;
      if (dig1_q == 4'd9) begin
        inc1 = 4'd0;
        inc2 = dig2_q + 4'd1;
      end else begin
        inc1 = dig1_q + 4'd1;
      end
    end else begin
      inc0 = dig0_q + 4'd1;
    end
  end

  // BCD -1 with ripple borrow; only used when the score is above 000
  always_comb begin
    dec2 = dig2_q;
    dec1 = dig1_q;
    dec0 = dig0_q;
    if (dig0_q == 4'd0) begin
      dec0 = 4'd9;
      if (dig1_q == 4'd0) begin
        dec1 = 4'd9;
        dec2 = dig2_q - 4'd1;
      end else begin
        dec1 = dig1_q - 4'd1;
      end
    end else begin
      dec0 = dig0_q - 4'd1;
    end
  end

  // Sequencer: clear overrides everything, edges only accepted in IDLE
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dig2_d  = dig2_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    prior_d = req;

    if (clear) begin
      state_d = ST_IDLE;
      rem_d   = 2'd0;
      dig2_d  = 4'd0;
      dig1_d  = 4'd0;
      dig0_d  = 4'd0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise[3]) begin
            state_d = ST_DEC;
            rem_d   = 2'd1;
          end else if (rise[2]) begin
            state_d = ST_INC;
            rem_d   = 2'd3;
          end else if (rise[1]) begin
            state_d = ST_INC;
            rem_d   = 2'd2;
          end else if (rise[0]) begin
            state_d = ST_INC;
            rem_d   = 2'd1;
          end
        end

        ST_INC: begin
          if (at_max) begin
            sat_d   = 1'b1;
            rem_d   = 2'd0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            dig2_d = inc2;
            dig1_d = inc1;
            dig0_d = inc0;
            if (rem_q == 2'd1) begin
              rem_d   = 2'd0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - 2'd1;
            end
          end
        end

        ST_DEC: begin
          if (at_min) begin
            sat_d   = 1'b1;
            rem_d   = 2'd0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            dig2_d = dec2;
            dig1_d = dec1;
            dig0_d = dec0;
            if (rem_q == 2'd1) begin
              rem_d   = 2'd0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - 2'd1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      rem_q   <= 2'd0;
      dig2_q  <= 4'd0;
      dig1_q  <= 4'd0;
      dig0_q  <= 4'd0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      prior_q <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dig2_q  <= dig2_d;
      dig1_q  <= dig1_d;
      dig0_q  <= dig0_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      prior_q <= prior_d;
    end
  end

  assign BCD2 = dig2_q;
  assign BCD1 = dig1_q;
  assign BCD0 = dig0_q;
  assign busy = (state_q != ST_IDLE);
  assign sat  = sat_q;
  assign done = done_q;

endmodule

// File: tb/tb_contador_pontos_bcd.sv
// Bench for contador_pontos_bcd: integer-score reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.

module tb_contador_pontos_bcd;

  logic       clk = 1'b0;
  logic       nReset = 1'b1;
  logic       add1 = 1'b0, add2 = 1'b0, add3 = 1'b0, sub1 = 1'b0, clear = 1'b0;
  logic [3:0] BCD2, BCD1, BCD0;
  logic       busy, sat, done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  contador_pontos_bcd dut (
    .clk(clk), .nReset(nReset), .add1(add1), .add2(add2), .add3(add3),
    .sub1(sub1), .clear(clear), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
    .busy(busy), .sat(sat), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer score and a count of points still owed
  int score = 0;
  int pend = 0;
  bit up = 1'b0;
  bit m_busy = 1'b0, m_sat = 1'b0, m_done = 1'b0;
  bit p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, ps = 1'b0;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      score = 0; pend = 0; m_busy = 0; m_sat = 0; m_done = 0;
      p1 = 0; p2 = 0; p3 = 0; ps = 0;
    end else begin
      m_done = 0;
      if (clear) begin
        score = 0; m_sat = 0; m_busy = 0; pend = 0;
      end else if (m_busy) begin
        if (up ? (score == 999) : (score == 0)) begin
          m_sat = 1; pend = 0;
        end else begin
          score = up ? score + 1 : score - 1;
          pend = pend - 1;
        end
        if (pend == 0) begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        if (sub1 && !ps)      begin m_busy = 1; up = 0; pend = 1; end
        else if (add3 && !p3) begin m_busy = 1; up = 1; pend = 3; end
        else if (add2 && !p2) begin m_busy = 1; up = 1; pend = 2; end
        else if (add1 && !p1) begin m_busy = 1; up = 1; pend = 1; end
      end
      p1 = add1; p2 = add2; p3 = add3; ps = sub1;
    end
  end

  // Cycle compare against the model, away from the rising edge
  always @(negedge clk) begin
    logic [3:0] e2, e1, e0;
    if (chk_en) begin
      e2 = 4'(score / 100);
      e1 = 4'((score / 10) % 10);
      e0 = 4'(score % 10);
      chk("model", {17'd0, BCD2, BCD1, BCD0, busy, sat, done},
                   {17'd0, e2, e1, e0, m_busy, m_sat, m_done});
    end
  end

  task automatic op(input int kind);
    int n;
    @(negedge clk);
    case (kind)
      0: sub1 = 1'b1;
      1: add1 = 1'b1;
      2: add2 = 1'b1;
      default: add3 = 1'b1;
    endcase
    @(negedge clk);
    {add1, add2, add3, sub1} = 4'b0;
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 8) begin
      fails++;
      $display("FAIL op_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic set_score(input int v);
    int r;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    r = v;
    while (r >= 3) begin op(3); r -= 3; end
    if (r > 0) op(r);
  endtask

  initial begin
    #3 nReset = 1'b0;
    #1 chk("reset_state", {BCD2, BCD1, BCD0, busy, sat, done}, {12'h000, 3'b000});
    @(negedge clk);
    nReset = 1'b1;
    chk_en = 1'b1;

    // 000 + 3: one point per edge, done on the third
    set_score(0);
    @(negedge clk); add3 = 1'b1;
    @(negedge clk); add3 = 1'b0;
    chk("a3_k",  {BCD2, BCD1, BCD0, busy, done}, {12'h000, 2'b10});
    @(negedge clk); chk("a3_k1", {BCD2, BCD1, BCD0, busy, done}, {12'h001, 2'b10});
    @(negedge clk); chk("a3_k2", {BCD2, BCD1, BCD0, busy, done}, {12'h002, 2'b10});
    @(negedge clk); chk("a3_k3", {BCD2, BCD1, BCD0, busy, done}, {12'h003, 2'b01});
    @(negedge clk); chk("a3_after", {busy, done}, 2'b00);

    // carry through tens and hundreds
    set_score(98);
    op(3);
    chk("carry_101", {BCD2, BCD1, BCD0, sat}, {12'h101, 1'b0});

    // saturation at 999
    set_score(998);
    @(negedge clk); add3 = 1'b1;
    @(negedge clk); add3 = 1'b0;
    chk("sat_k",  {BCD2, BCD1, BCD0, busy, sat, done}, {12'h998, 3'b100});
    @(negedge clk); chk("sat_k1", {BCD2, BCD1, BCD0, busy, sat, done}, {12'h999, 3'b100});
    @(negedge clk); chk("sat_k2", {BCD2, BCD1, BCD0, busy, sat, done}, {12'h999, 3'b011});
    repeat (2) @(negedge clk);
    chk("sat_sticky", {BCD2, BCD1, BCD0, sat}, {12'h999, 1'b1});

    // borrow and floor
    set_score(100);
    op(0);
    chk("borrow_099", {BCD2, BCD1, BCD0, sat}, {12'h099, 1'b0});
    set_score(0);
    op(0);
    chk("floor_000", {BCD2, BCD1, BCD0, sat}, {12'h000, 1'b1});

    // sub1 beats add2; add1 edge while busy is dropped
    set_score(50);
    @(negedge clk); add2 = 1'b1; sub1 = 1'b1;
    @(negedge clk); add2 = 1'b0; sub1 = 1'b0; add1 = 1'b1;
    chk("prio_busy", busy, 1'b1);
    @(negedge clk); chk("prio_049", {BCD2, BCD1, BCD0, busy, done}, {12'h049, 2'b01});
    repeat (3) @(negedge clk);
    add1 = 1'b0;
    chk("prio_ign", {BCD2, BCD1, BCD0, busy}, {12'h049, 1'b0});

    // clear mid-operation
    set_score(10);
    @(negedge clk); add3 = 1'b1;
    @(negedge clk); add3 = 1'b0;
    @(negedge clk); chk("clr_011", {BCD2, BCD1, BCD0}, 12'h011); clear = 1'b1;
    @(negedge clk); chk("clr_000", {BCD2, BCD1, BCD0, busy, done}, {12'h000, 2'b00}); clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_hold", {BCD2, BCD1, BCD0, busy}, {12'h000, 1'b0});

    // async reset mid-operation
    set_score(10);
    @(negedge clk); add3 = 1'b1;
    @(negedge clk); add3 = 1'b0;
    @(negedge clk);
    #2 nReset = 1'b0;
    #1 chk("rst_now", {BCD2, BCD1, BCD0, busy, sat, done}, {12'h000, 3'b000});
    @(negedge clk); nReset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_nopend", {BCD2, BCD1, BCD0, busy}, {12'h000, 1'b0});

    // input high across reset release counts as an edge, once
    @(negedge clk); nReset = 1'b0; add1 = 1'b1;
    @(negedge clk); nReset = 1'b1;
    @(negedge clk); chk("rel_busy", busy, 1'b1);
    @(negedge clk); chk("rel_001", {BCD2, BCD1, BCD0, done}, {12'h001, 1'b1});
    repeat (3) @(negedge clk);
    chk("rel_once", {BCD2, BCD1, BCD0, busy}, {12'h001, 1'b0});
    add1 = 1'b0;

    // random traffic against the model
    repeat (4000) begin
      @(negedge clk);
      add1  = ($urandom_range(0, 3) == 0);
      add2  = ($urandom_range(0, 3) == 0);
      add3  = ($urandom_range(0, 2) == 0);
      sub1  = ($urandom_range(0, 4) == 0);
      clear = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 nReset = 1'b0;
        #1 nReset = 1'b1;
      end
    end
    @(negedge clk);
    {add1, add2, add3, sub1, clear} = 5'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
